wb_regfile: RTL and testbench

//   Write-back end of the MEM/WB interface. Consumes MEM/WB register outputs and selects
//   the ALU result or load data. Load data is byte/half-aligned and sign/zero-extended.
//   The result is committed to the 32-entry integer register file.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/load_extend.sv | 50 +++++
 rtl/wb_regfile.sv | 92 +++++++++
 tb/tb_wb_regfile.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the write-back stage and load path.
//   XLEN          datapath width
//   REG_ADDR_W    register-index width
//   LD_*          load funct3 encodings
//   WB_SEL_*      write-back source select encodings
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extractor: picks the addressed byte or halfword out of
// an aligned memory word and sign- or zero-extends it.
//   funct3  in   load type (LB/LH/LW/LBU/LHU; anything else passes the word through)
//   off     in   low two address bits
//   raw     in   aligned-word read data
//   data    out  extracted, extended value
module load_extend #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);
  import rv32i_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; off[0] is ignored for halfwords since misalignment traps upstream.
  always_comb begin
    byte_sel = raw[7:0];
    case (off)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      2'd3:    byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    if (off[1]) begin
      half_sel = raw[31:16];
    end else begin
      half_sel = raw[15:0];
    end
  end

  // Extension by load type.
  always_comb begin
    data = raw;
    case (funct3)
      LD_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
      LD_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
      LD_W:    data = raw;
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and integer register file. Selects ALU result or extended load
// data, commits it to the register array, and serves two combinational read ports
// with optional same-cycle write-to-read bypass.
//   clk, rst_n                 clock, async active-low reset (clears the array)
//   enable                     commit enable (low = stall)
//   reg_wr_in, mux_reg_wr_in   write request, source select (1 = load data)
//   ula_res_in, mem_res_in     ALU result / load address, raw load word
//   rd_in, ld_funct3_in        destination register, load type
//   rs1_addr/rs2_addr          read addresses; rs1_data/rs2_data read data
//   wb_data_out, wb_we_out     write-back value and effective write enable
module wb_regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            reg_wr_in,
  input  logic                            mux_reg_wr_in,
  input  logic [XLEN-1:0]                 ula_res_in,
  input  logic [XLEN-1:0]                 mem_res_in,
  input  logic [rv32i_pkg::REG_ADDR_W-1:0] rd_in,
  input  logic [2:0]                      ld_funct3_in,
  input  logic [rv32i_pkg::REG_ADDR_W-1:0] rs1_addr,
  input  logic [rv32i_pkg::REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]                 rs1_data,
  output logic [XLEN-1:0]                 rs2_data,
  output logic [XLEN-1:0]                 wb_data_out,
  output logic                            wb_we_out
);
  import rv32i_pkg::*;

  // x0 is not stored; index 0 is short-circuited on every access.
  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [XLEN-1:0] load_data;
  logic            rd_valid;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (ld_funct3_in),
    .off    (ula_res_in[1:0]),
    .raw    (mem_res_in),
    .data   (load_data)
  );

  // Write-back value, and the write enable gated off in reset so no bypass leaks out.
  always_comb begin
    rd_valid = (rd_in != {REG_ADDR_W{1'b0}}) && (int'(rd_in) < NREGS);
    wb_we_out = rst_n & enable & reg_wr_in & rd_valid;
    if (mux_reg_wr_in == WB_SEL_MEM) begin
      wb_data_out = load_data;
    end else begin
      wb_data_out = ula_res_in;
    end
  end

  // Register array commit; reset clears every stored entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= {XLEN{1'b0}};
      end
    end else if (wb_we_out) begin
      regs[rd_in] <= wb_data_out;
    end
  end

  // Read port 1.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    if (rs1_addr == {REG_ADDR_W{1'b0}} || int'(rs1_addr) >= NREGS) begin
      rs1_data = {XLEN{1'b0}};
    end else if (BYPASS && wb_we_out && (rs1_addr == rd_in)) begin
      rs1_data = wb_data_out;
    end else begin
      rs1_data = regs[rs1_addr];
    end
  end

  // Read port 2.
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    if (rs2_addr == {REG_ADDR_W{1'b0}} || int'(rs2_addr) >= NREGS) begin
      rs2_data = {XLEN{1'b0}};
    end else if (BYPASS && wb_we_out && (rs2_addr == rd_in)) begin
      rs2_data = wb_data_out;
    end else begin
      rs2_data = regs[rs2_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a bypassing instance and a non-bypassing instance
// share the same stimulus.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        reg_wr_in = 1'b0;
  logic        mux_reg_wr_in = 1'b0;
  logic [31:0] ula_res_in = 32'h0;
  logic [31:0] mem_res_in = 32'h0;
  logic [4:0]  rd_in = 5'd0;
  logic [2:0]  ld_funct3_in = 3'b010;
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;

  logic [31:0] rs1_data, rs2_data, wb_data_out;
  logic        wb_we_out;
  logic [31:0] nb_rs1_data, nb_rs2_data, nb_wb_data_out;
  logic        nb_wb_we_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .reg_wr_in(reg_wr_in),
    .mux_reg_wr_in(mux_reg_wr_in), .ula_res_in(ula_res_in), .mem_res_in(mem_res_in),
    .rd_in(rd_in), .ld_funct3_in(ld_funct3_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data_out(wb_data_out), .wb_we_out(wb_we_out)
  );

  wb_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .reg_wr_in(reg_wr_in),
    .mux_reg_wr_in(mux_reg_wr_in), .ula_res_in(ula_res_in), .mem_res_in(mem_res_in),
    .rd_in(rd_in), .ld_funct3_in(ld_funct3_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data), .wb_data_out(nb_wb_data_out),
    .wb_we_out(nb_wb_we_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_wr(input logic wr, input logic mux, input logic [31:0] ula,
                        input logic [4:0] rd, input logic [2:0] f3);
    reg_wr_in = wr;
    mux_reg_wr_in = mux;
    ula_res_in = ula;
    rd_in = rd;
    ld_funct3_in = f3;
  endtask

  initial begin
    // Reset state, including a write request while in reset.
    enable = 1'b1;
    set_wr(1'b1, 1'b0, 32'h1234, 5'd5, 3'b010);
    rs1_addr = 5'd5;
    rs2_addr = 5'd5;
    #12;
    check("reset_we", {31'd0, wb_we_out}, 32'h0);
    check("reset_rs1", rs1_data, 32'h0);
    tick();
    check("reset_no_write", rs1_data, 32'h0);

    // Release reset, write x5, then async reset clears it with no edge.
    rst_n = 1'b1;
    #1;
    check("bypass_x5", rs1_data, 32'h1234);
    tick();
    reg_wr_in = 1'b0;
    #1;
    check("x5_written", rs1_data, 32'h1234);
    rst_n = 1'b0;
    #1;
    check("async_clear", rs1_data, 32'h0);
    #1;
    rst_n = 1'b1;
    tick();

    // ALU write to x7.
    set_wr(1'b1, 1'b0, 32'hDEADBEEF, 5'd7, 3'b010);
    rs1_addr = 5'd0;
    rs2_addr = 5'd6;
    #1;
    check("alu_we", {31'd0, wb_we_out}, 32'h1);
    check("alu_wbdata", wb_data_out, 32'hDEADBEEF);
    tick();
    reg_wr_in = 1'b0;
    rs2_addr = 5'd7;
    #1;
    check("alu_read_x7", rs2_data, 32'hDEADBEEF);
    check("alu_read_x7_nb", nb_rs2_data, 32'hDEADBEEF);

    // Loads from 0x80FF7F01 into x3.
    mem_res_in = 32'h80FF7F01;
    set_wr(1'b1, 1'b1, 32'h00001003, 5'd3, 3'b000);
    #1;
    check("lb_off3", wb_data_out, 32'hFFFFFF80);
    set_wr(1'b1, 1'b1, 32'h00001003, 5'd3, 3'b100);
    #1;
    check("lbu_off3", wb_data_out, 32'h00000080);
    set_wr(1'b1, 1'b1, 32'h00001001, 5'd3, 3'b000);
    #1;
    check("lb_off1", wb_data_out, 32'h0000007F);
    set_wr(1'b1, 1'b1, 32'h00001002, 5'd3, 3'b001);
    #1;
    check("lh_off2", wb_data_out, 32'hFFFF80FF);
    set_wr(1'b1, 1'b1, 32'h00001003, 5'd3, 3'b101);
    #1;
    check("lhu_off3", wb_data_out, 32'h000080FF);
    set_wr(1'b1, 1'b1, 32'h00001000, 5'd3, 3'b101);
    #1;
    check("lhu_off0", wb_data_out, 32'h00007F01);
    set_wr(1'b1, 1'b1, 32'h00001002, 5'd3, 3'b010);
    #1;
    check("lw", wb_data_out, 32'h80FF7F01);
    set_wr(1'b1, 1'b1, 32'h00001002, 5'd3, 3'b000);
    tick();
    reg_wr_in = 1'b0;
    rs1_addr = 5'd3;
    #1;
    check("lb_committed_x3", rs1_data, 32'hFFFFFFFF);

    // Bypass: preload x9, then rewrite it with both ports watching.
    set_wr(1'b1, 1'b0, 32'h11111111, 5'd9, 3'b010);
    tick();
    set_wr(1'b1, 1'b0, 32'hA5A5A5A5, 5'd9, 3'b010);
    rs1_addr = 5'd9;
    rs2_addr = 5'd9;
    #1;
    check("byp_rs1", rs1_data, 32'hA5A5A5A5);
    check("byp_rs2", rs2_data, 32'hA5A5A5A5);
    check("nobyp_rs1_old", nb_rs1_data, 32'h11111111);
    check("nobyp_rs2_old", nb_rs2_data, 32'h11111111);
    tick();
    reg_wr_in = 1'b0;
    #1;
    check("nobyp_rs1_new", nb_rs1_data, 32'hA5A5A5A5);
    check("byp_rs2_after", rs2_data, 32'hA5A5A5A5);

    // x0 is never written.
    set_wr(1'b1, 1'b0, 32'hFFFFFFFF, 5'd0, 3'b010);
    rs1_addr = 5'd0;
    #1;
    check("x0_we", {31'd0, wb_we_out}, 32'h0);
    check("x0_before", rs1_data, 32'h0);
    tick();
    check("x0_after", rs1_data, 32'h0);

    // Stall, then commit.
    enable = 1'b0;
    set_wr(1'b1, 1'b0, 32'h00000055, 5'd4, 3'b010);
    rs1_addr = 5'd4;
    #1;
    check("stall_we", {31'd0, wb_we_out}, 32'h0);
    check("stall_nobypass", rs1_data, 32'h0);
    tick();
    check("stall_unchanged", rs1_data, 32'h0);
    enable = 1'b1;
    #1;
    check("commit_bypass", rs1_data, 32'h55);
    check("commit_nb_old", nb_rs1_data, 32'h0);
    tick();
    reg_wr_in = 1'b0;
    #1;
    check("commit_x4", rs1_data, 32'h55);
    check("commit_x4_nb", nb_rs1_data, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
